decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered, parametrised RISC-V instruction decode stage between fetch and execute. It decodes RV32I/RV64I base families, with optional M-extension and RV64 word-op families. Decoded control, immediate, PC and raw instruction pass through a 2-entry skid buffer with valid/ready handshakes on both sides. It also detects illegal encodings and supports pipeline flush.

Parameters:
XLEN, 32, datapath width; 32 or 64 only
EN_M, 0, 1 = decode MUL/DIV (funct7=0000001 on OP/OP-32), 0 = treat as illegal
EN_W, (XLEN==64), 1 = decode OP-IMM-32 (00110) and OP-32 (01110); forced 0 when XLEN=32

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_valid  in  1  fetch presents instruction
o_ready  out  1  stage can accept
i_instruction  in  32  raw instruction
i_pc  in  XLEN  PC of instruction
i_flush  in  1  discard all held entries
o_valid  out  1  decoded entry available
i_ready  in  1  execute accepts
o_decoded  out  decode_out_s  control fields: control_ex_s plus illegal, muldiv, word_op
o_imm  out  XLEN  sign-extended immediate
o_pc  out  XLEN  PC of o_decoded
o_instruction  out  32  raw instruction, kept for trap reporting

Behaviour:
- Reset: both entries invalid; o_valid=0, o_ready=1; o_decoded, o_imm, o_pc and o_instruction are 0.
- Transfer rules: an input transfer occurs when i_valid && o_ready; an output transfer occurs when o_valid && i_ready.
- Latency: 1 cycle. An instruction accepted in cycle N appears at the outputs in cycle N+1.
- Skid buffer: the main register drives the outputs; the skid register holds one overflow entry.
  - o_ready = !skid_valid (registered; no combinational path from i_ready).
  - Accepting while main is full and not draining loads skid.
  - On drain, skid moves to main in the same cycle. Any concurrent input then goes to skid if main is refilled, otherwise to main.
- Ordering: strict FIFO; no drops, no duplicates.
- Count states: EMPTY(0), ONE(1), FULL(2).
  - EMPTY -push-> ONE.
  - ONE -push, no pop-> FULL.
  - ONE -pop, no push-> EMPTY.
  - ONE -push & pop-> ONE.
  - FULL -pop-> ONE. Push cannot occur in FULL.
- Flush: i_flush has priority over everything. The next cycle is EMPTY with o_valid=0, and any same-cycle input transfer is discarded. i_rst has priority over i_flush.
- Family decode is on bits[6:2], valid only if bits[1:0]=11:
  - LUI=01101, AUIPC=00101, JAL=11011, JALR=11001, BRANCH=11000, LOAD=00000, STORE=01000, OP-IMM=00100, OP=01100.
  - With EN_W: OP-IMM-32=00110, OP-32=01110.
- rd is forced to 0 for STORE and BRANCH. fcs_opcode=[14:12], rs1=[19:15], rs2=[24:20].
- iop = LUI | STORE | JALR | (OP & [30] & !muldiv) | (OP-IMM & funct3=101 & [30]); the same OP/OP-IMM terms apply to the word-op families.
- Immediates are sign-extended to XLEN:
  - I-type for OP-IMM, LOAD, JALR.
  - U-type for LUI, AUIPC.
  - J-type for JAL, S-type for STORE, B-type for BRANCH.
  - 0 when illegal.
- Illegal if any of the following; then illegal=1, every other control flag is 0, rd=0:
  - bits[1:0]!=11, or unknown family.
  - OP funct7 not in {0000000, 0100000 (only for funct3 000/101)}; 0000001 is legal only with EN_M.
  - Shift-immediate upper bits nonzero: [31:25] for XLEN=32; [31:26] for XLEN=64 (bit 30 excepted for SRAI).
  - JALR funct3!=000, or BRANCH funct3 in {010, 011}.
  - LOAD funct3=111; funct3=011 or 110 only when XLEN=32.
  - STORE funct3>=100, or funct3=011 when XLEN=32.
- word_op = 1 for the OP-IMM-32 and OP-32 families. muldiv = 1 for a legal M-extension encoding.

Decomposition:
- rapid_pkg gains:
  - decode_out_s (control_ex_s plus illegal, muldiv, word_op).
  - Opcode family localparams, moved out of global scope; add OPIMM32 and OP32.
  - FUNCT7_BASE, FUNCT7_ALT and FUNCT7_MULDIV constants.
- Sub-module decode_comb: combinational; parameters XLEN, EN_M, EN_W; input is the instruction; outputs are decode_out_s and the immediate.
- decode_stage contains only the skid buffer and flush control.

Test Plan:
- Reset then idle: i_rst=1 for 2 cycles -> o_valid=0, o_ready=1, o_imm=0.
- ADDI x5,x1,-1 (0xFFF08293) with i_ready=1 -> next cycle o_valid=1, alu_imm=1, rd=5, rs1=1, o_imm=all ones, illegal=0.
- Back-pressure: i_ready=0, push SW x2,8(x3) then BEQ.
  - Push SW -> rd=0, iop=1, o_imm=8.
  - Push BEQ -> o_ready=0 after the second push.
  - Raise i_ready -> SW then BEQ out in order on consecutive cycles, o_ready=1.
- Flush with FULL plus a concurrent push -> next cycle o_valid=0, o_ready=1; the pushed instruction never appears.
- Illegal encodings: 0x00000000, 0x0000707B, and SLLI with [25]=1 at XLEN=32 -> illegal=1 and all family flags 0.
- XLEN=64, EN_M=0: ADDIW (0x0010809B) -> word_op=1; MUL (0x02208033) -> illegal=1. With EN_M=1, MUL -> muldiv=1, alu_reg=1, iop=0.

Source files
------------

// File: rtl/rapid_pkg.sv
// Shared decode definitions: opcode families, funct7 constants and the
// decoded-instruction structures passed from decode to execute.
package rapid_pkg;

    localparam logic [4:0] OPC_LOAD    = 5'b00000;
    localparam logic [4:0] OPC_OPIMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC   = 5'b00101;
    localparam logic [4:0] OPC_OPIMM32 = 5'b00110;
    localparam logic [4:0] OPC_STORE   = 5'b01000;
    localparam logic [4:0] OPC_OP      = 5'b01100;
    localparam logic [4:0] OPC_LUI     = 5'b01101;
    localparam logic [4:0] OPC_OP32    = 5'b01110;
    localparam logic [4:0] OPC_BRANCH  = 5'b11000;
    localparam logic [4:0] OPC_JALR    = 5'b11001;
    localparam logic [4:0] OPC_JAL     = 5'b11011;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic       lui;
        logic       auipc;
        logic       jal;
        logic       jalr;
        logic       branch;
        logic       load;
        logic       store;
        logic       alu_imm;
        logic       alu_reg;
        logic       iop;
        logic [2:0] fcs_opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } control_ex_s;

    typedef struct packed {
        control_ex_s ctrl;
        logic        illegal;
        logic        muldiv;
        logic        word_op;
    } decode_out_s;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } count_e;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I/RV64I decoder with optional M and word-op
// families; illegal encodings collapse to a single illegal flag.
module decode_comb
    import rapid_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int EN_M = 0,
    parameter int EN_W = (XLEN == 64)
) (
    input  logic [31:0]     i_instruction,
    output decode_out_s     o_decoded,
    output logic [XLEN-1:0] o_imm
);
    localparam bit IS64  = (XLEN == 64);
    localparam bit HAS_W = IS64 && (EN_W != 0);
    localparam bit HAS_M = (EN_M != 0);

    logic [4:0]      family;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            is_word;
    logic            shift_bad;
    logic            legal;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
    decode_out_s     dec;

    assign family  = i_instruction[6:2];
    assign funct3  = i_instruction[14:12];
    assign funct7  = i_instruction[31:25];
    assign is_word = (family == OPC_OPIMM32) || (family == OPC_OP32);

    assign imm_i = XLEN'($signed(i_instruction[31:20]));
    assign imm_s = XLEN'($signed({i_instruction[31:25], i_instruction[11:7]}));
    assign imm_b = XLEN'($signed({i_instruction[31], i_instruction[7],
                                  i_instruction[30:25], i_instruction[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({i_instruction[31:12], 12'h000}));
    assign imm_j = XLEN'($signed({i_instruction[31], i_instruction[19:12],
                                  i_instruction[20], i_instruction[30:21], 1'b0}));

    // Shamt is 6 bits only for full-width RV64 shifts; bit 30 is the SRAI selector.
    assign shift_bad = i_instruction[31] || (i_instruction[29:26] != 4'b0000)
                     || (i_instruction[25] && !(IS64 && !is_word))
                     || (i_instruction[30] && (funct3 == 3'b001));

    always_comb begin
        dec                 = '0;
        imm_sel             = '0;
        legal               = 1'b1;
        dec.ctrl.fcs_opcode = funct3;
        dec.ctrl.rs1        = i_instruction[19:15];
        dec.ctrl.rs2        = i_instruction[24:20];
        dec.ctrl.rd         = i_instruction[11:7];
        if (i_instruction[1:0] != 2'b11) begin
            legal = 1'b0;
        end else begin
            case (family)
                OPC_LUI: begin
                    dec.ctrl.lui = 1'b1;
                    dec.ctrl.iop = 1'b1;
                    imm_sel      = imm_u;
                end
                OPC_AUIPC: begin
                    dec.ctrl.auipc = 1'b1;
                    imm_sel        = imm_u;
                end
                OPC_JAL: begin
                    dec.ctrl.jal = 1'b1;
                    imm_sel      = imm_j;
                end
                OPC_JALR: begin
                    legal         = (funct3 == 3'b000);
                    dec.ctrl.jalr = 1'b1;
                    dec.ctrl.iop  = 1'b1;
                    imm_sel       = imm_i;
                end
                OPC_BRANCH: begin
                    legal           = (funct3 != 3'b010) && (funct3 != 3'b011);
                    dec.ctrl.branch = 1'b1;
                    dec.ctrl.rd     = 5'd0;
                    imm_sel         = imm_b;
                end
                OPC_LOAD: begin
                    legal         = (funct3 != 3'b111)
                                  && (IS64 || ((funct3 != 3'b011) && (funct3 != 3'b110)));
                    dec.ctrl.load = 1'b1;
                    imm_sel       = imm_i;
                end
                OPC_STORE: begin
                    legal          = !funct3[2] && (IS64 || (funct3 != 3'b011));
                    dec.ctrl.store = 1'b1;
                    dec.ctrl.iop   = 1'b1;
                    dec.ctrl.rd    = 5'd0;
                    imm_sel        = imm_s;
                end
                OPC_OPIMM, OPC_OPIMM32: begin
                    legal = !is_word || HAS_W;
                    if (((funct3 == 3'b001) || (funct3 == 3'b101)) && shift_bad) begin
                        legal = 1'b0;
                    end
                    dec.ctrl.alu_imm = 1'b1;
                    dec.word_op      = is_word;
                    dec.ctrl.iop     = (funct3 == 3'b101) && i_instruction[30];
                    imm_sel          = imm_i;
                end
                OPC_OP, OPC_OP32: begin
                    case (funct7)
                        FUNCT7_BASE:   legal = 1'b1;
                        FUNCT7_ALT:    legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                        FUNCT7_MULDIV: begin
                            legal      = HAS_M;
                            dec.muldiv = 1'b1;
                        end
                        default:       legal = 1'b0;
                    endcase
                    if (is_word && !HAS_W) begin
                        legal = 1'b0;
                    end
                    dec.ctrl.alu_reg = 1'b1;
                    dec.word_op      = is_word;
                    dec.ctrl.iop     = i_instruction[30] && !dec.muldiv;
                end
                default: legal = 1'b0;
            endcase
        end
        // Register fields survive so a trap handler can still report them.
        if (!legal) begin
            dec                 = '0;
            dec.illegal         = 1'b1;
            dec.ctrl.fcs_opcode = funct3;
            dec.ctrl.rs1        = i_instruction[19:15];
            dec.ctrl.rs2        = i_instruction[24:20];
            imm_sel             = '0;
        end
    end

    assign o_decoded = dec;
    assign o_imm     = imm_sel;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoded entries flow through a two-entry skid
// buffer so o_ready never depends combinationally on i_ready.
module decode_stage
    import rapid_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int EN_M = 0,
    parameter int EN_W = (XLEN == 64)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instruction,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output decode_out_s     o_decoded,
    output logic [XLEN-1:0] o_imm,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_instruction
);
    localparam int ENTRY_W = $bits(decode_out_s) + 2 * XLEN + 32;

    decode_out_s        dec_in;
    logic [XLEN-1:0]    imm_in;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] main_q, main_d, skid_q, skid_d;
    count_e             count_q, count_d;
    logic               push, pop;

    decode_comb #(
        .XLEN (XLEN),
        .EN_M (EN_M),
        .EN_W (EN_W)
    ) u_decode (
        .i_instruction (i_instruction),
        .o_decoded     (dec_in),
        .o_imm         (imm_in)
    );

    assign in_entry = {dec_in, imm_in, i_pc, i_instruction};
    assign o_ready  = (count_q != CNT_FULL);
    assign o_valid  = (count_q != CNT_EMPTY);
    assign push     = i_valid && o_ready;
    assign pop      = o_valid && i_ready;
    assign {o_decoded, o_imm, o_pc, o_instruction} = main_q;

    // Main always holds the oldest entry; skid only fills while main is stalled.
    always_comb begin
        count_d = count_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_flush) begin
            count_d = CNT_EMPTY;
        end else begin
            case (count_q)
                CNT_EMPTY: begin
                    if (push) begin
                        count_d = CNT_ONE;
                        main_d  = in_entry;
                    end
                end
                CNT_ONE: begin
                    if (push && !pop) begin
                        count_d = CNT_FULL;
                        skid_d  = in_entry;
                    end else if (push && pop) begin
                        main_d = in_entry;
                    end else if (pop) begin
                        count_d = CNT_EMPTY;
                    end
                end
                CNT_FULL: begin
                    if (pop) begin
                        count_d = CNT_ONE;
                        main_d  = skid_q;
                    end
                end
                default: count_d = CNT_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= CNT_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            count_q <= count_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench: three decode_stage configurations share one stimulus
// stream and are compared against a queue model plus an instruction-level decoder.
module tb_decode_stage;
    import rapid_pkg::*;

    localparam logic [31:0] I_ADDI  = 32'hFFF08293;
    localparam logic [31:0] I_SW    = 32'h0021A423;
    localparam logic [31:0] I_BEQ   = 32'h00208863;
    localparam logic [31:0] I_LUI   = 32'h123452B7;
    localparam logic [31:0] I_SLLI  = 32'h02009093;
    localparam logic [31:0] I_ADDIW = 32'h0010809B;
    localparam logic [31:0] I_MUL   = 32'h02208033;
    localparam logic [4:0]  FAMS [11] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001,
                                          5'b11000, 5'b00000, 5'b01000, 5'b00100,
                                          5'b01100, 5'b00110, 5'b01110};

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] instr;
    logic [63:0] pc;

    logic        a_ready, a_valid, b_ready, b_valid, c_ready, c_valid;
    decode_out_s a_dec, b_dec, c_dec;
    logic [31:0] a_imm, a_pc, a_instr, b_instr, c_instr;
    logic [63:0] b_imm, b_pc, c_imm, c_pc;

    logic [31:0] q_ins [$];
    logic [63:0] q_pc  [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .EN_M(0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(a_ready),
        .i_instruction(instr), .i_pc(pc[31:0]), .i_flush(flush), .o_valid(a_valid),
        .i_ready(out_ready), .o_decoded(a_dec), .o_imm(a_imm), .o_pc(a_pc),
        .o_instruction(a_instr));

    decode_stage #(.XLEN(64), .EN_M(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(b_ready),
        .i_instruction(instr), .i_pc(pc), .i_flush(flush), .o_valid(b_valid),
        .i_ready(out_ready), .o_decoded(b_dec), .o_imm(b_imm), .o_pc(b_pc),
        .o_instruction(b_instr));

    decode_stage #(.XLEN(64), .EN_M(0)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(c_ready),
        .i_instruction(instr), .i_pc(pc), .i_flush(flush), .o_valid(c_valid),
        .i_ready(out_ready), .o_decoded(c_dec), .o_imm(c_imm), .o_pc(c_pc),
        .o_instruction(c_instr));

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Instruction-level decoder: classify by family, then apply the legality rules.
    function automatic void refDecode(input logic [31:0] ins, input bit is64, input bit en_m,
                                      output decode_out_s d, output logic [63:0] imm);
        logic [4:0]  fam   = ins[6:2];
        logic [2:0]  f3    = ins[14:12];
        logic [6:0]  f7    = ins[31:25];
        logic [6:0]  upper = ins[31:25];
        bit          wfam  = (fam == 5'b00110) || (fam == 5'b01110);
        bit          ok    = 1'b1;
        logic [63:0] imm_i = 64'($signed(ins[31:20]));
        logic [63:0] imm_s = 64'($signed({ins[31:25], ins[11:7]}));
        logic [63:0] imm_b = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        logic [63:0] imm_u = 64'($signed({ins[31:12], 12'h000}));
        logic [63:0] imm_j = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        d = '0;
        imm = '0;
        d.ctrl.fcs_opcode = f3;
        d.ctrl.rs1 = ins[19:15];
        d.ctrl.rs2 = ins[24:20];
        d.ctrl.rd  = ins[11:7];
        if (ins[1:0] != 2'b11) ok = 1'b0;
        else case (fam)
            5'b01101: begin d.ctrl.lui = 1; d.ctrl.iop = 1; imm = imm_u; end
            5'b00101: begin d.ctrl.auipc = 1; imm = imm_u; end
            5'b11011: begin d.ctrl.jal = 1; imm = imm_j; end
            5'b11001: begin ok = (f3 == 0); d.ctrl.jalr = 1; d.ctrl.iop = 1; imm = imm_i; end
            5'b11000: begin ok = !(f3 == 2 || f3 == 3); d.ctrl.branch = 1; d.ctrl.rd = 0; imm = imm_b; end
            5'b00000: begin ok = (f3 != 7) && (is64 || (f3 != 3 && f3 != 6)); d.ctrl.load = 1; imm = imm_i; end
            5'b01000: begin
                ok = (f3 < 4) && (is64 || f3 != 3);
                d.ctrl.store = 1; d.ctrl.iop = 1; d.ctrl.rd = 0; imm = imm_s;
            end
            5'b00100, 5'b00110: begin
                ok = !wfam || is64;
                if (f3 == 1 || f3 == 5) begin
                    if (f3 == 5) upper[5] = 1'b0;
                    if (is64 && !wfam) upper[0] = 1'b0;
                    if (upper != 0) ok = 1'b0;
                end
                d.ctrl.alu_imm = 1; d.word_op = wfam; d.ctrl.iop = (f3 == 5) && ins[30]; imm = imm_i;
            end
            5'b01100, 5'b01110: begin
                ok = !wfam || is64;
                if (f7 == 7'h01) begin
                    if (!en_m) ok = 1'b0;
                    d.muldiv = 1'b1;
                end else if (f7 == 7'h20) begin
                    if (!(f3 == 0 || f3 == 5)) ok = 1'b0;
                end else if (f7 != 0) ok = 1'b0;
                d.ctrl.alu_reg = 1; d.word_op = wfam; d.ctrl.iop = ins[30] && !d.muldiv;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            d = '0;
            imm = '0;
            d.illegal = 1'b1;
            d.ctrl.fcs_opcode = f3;
            d.ctrl.rs1 = ins[19:15];
            d.ctrl.rs2 = ins[24:20];
        end
    endfunction

    task automatic checkDut(input string tag, input logic v, input logic r, input decode_out_s dec,
                            input logic [63:0] imm, input logic [63:0] p, input logic [31:0] ins,
                            input bit is64, input bit en_m);
        decode_out_s exp_dec;
        logic [63:0] exp_imm;
        logic [63:0] mask = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        checkOutput({tag, ".o_valid"}, 64'(v), 64'(q_ins.size() > 0));
        checkOutput({tag, ".o_ready"}, 64'(r), 64'(q_ins.size() < 2));
        if (q_ins.size() > 0) begin
            refDecode(q_ins[0], is64, en_m, exp_dec, exp_imm);
            checkOutput({tag, ".o_decoded"}, 64'(dec), 64'(exp_dec));
            checkOutput({tag, ".o_imm"}, imm, exp_imm & mask);
            checkOutput({tag, ".o_pc"}, p, q_pc[0] & mask);
            checkOutput({tag, ".o_instruction"}, 64'(ins), 64'(q_ins[0]));
        end
    endtask

    // One clock: drive inputs, advance the queue model at the edge, check at negedge.
    task automatic applyStimulus(input string tag, input bit v, input logic [31:0] ins,
                                 input logic [63:0] p, input bit fl, input bit rdy);
        bit exp_valid, exp_ready;
        in_valid  = v;
        instr     = ins;
        pc        = p;
        flush     = fl;
        out_ready = rdy;
        exp_valid = q_ins.size() > 0;
        exp_ready = q_ins.size() < 2;
        @(posedge clk);
        if (rst || fl) begin
            q_ins.delete();
            q_pc.delete();
        end else begin
            if (exp_valid && rdy) begin
                void'(q_ins.pop_front());
                void'(q_pc.pop_front());
            end
            if (v && exp_ready) begin
                q_ins.push_back(ins);
                q_pc.push_back(p);
            end
        end
        @(negedge clk);
        checkDut({tag, ".a"}, a_valid, a_ready, a_dec, 64'(a_imm), 64'(a_pc), a_instr, 1'b0, 1'b0);
        checkDut({tag, ".b"}, b_valid, b_ready, b_dec, b_imm, b_pc, b_instr, 1'b1, 1'b1);
        checkDut({tag, ".c"}, c_valid, c_ready, c_dec, c_imm, c_pc, c_instr, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] r = $urandom;
        int k = $urandom_range(0, 12);
        if (k < 11) r[6:0] = {FAMS[k], 2'b11};
        else if (k == 11) r[6:2] = 5'($urandom);
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0; out_ready = 1'b0;
        applyStimulus("reset0", 0, '0, '0, 0, 0);
        applyStimulus("reset1", 0, '0, '0, 0, 0);
        checkOutput("reset.o_decoded", 64'(a_dec), 64'd0);
        checkOutput("reset.o_imm", 64'(a_imm), 64'd0);
        checkOutput("reset.o_pc", b_pc, 64'd0);
        checkOutput("reset.o_instruction", 64'(c_instr), 64'd0);
        rst = 1'b0;
        applyStimulus("idle", 0, '0, '0, 0, 1);

        applyStimulus("addi", 1, I_ADDI, 64'h100, 0, 1);
        checkOutput("addi.alu_imm", 64'(a_dec.ctrl.alu_imm), 64'd1);
        checkOutput("addi.rd", 64'(a_dec.ctrl.rd), 64'd5);
        checkOutput("addi.rs1", 64'(a_dec.ctrl.rs1), 64'd1);
        checkOutput("addi.imm", 64'(a_imm), 64'hFFFF_FFFF);
        checkOutput("addi.illegal", 64'(a_dec.illegal), 64'd0);
        applyStimulus("drain", 0, '0, '0, 0, 1);

        applyStimulus("bp_sw", 1, I_SW, 64'h104, 0, 0);
        checkOutput("sw.rd", 64'(a_dec.ctrl.rd), 64'd0);
        checkOutput("sw.iop", 64'(a_dec.ctrl.iop), 64'd1);
        checkOutput("sw.imm", 64'(a_imm), 64'd8);
        applyStimulus("bp_beq", 1, I_BEQ, 64'h108, 0, 0);
        checkOutput("bp.o_ready_full", 64'(a_ready), 64'd0);
        applyStimulus("bp_out1", 0, '0, '0, 0, 1);
        checkOutput("bp.second_out", 64'(a_instr), 64'(I_BEQ));
        checkOutput("bp.o_ready_after", 64'(a_ready), 64'd1);
        applyStimulus("bp_out2", 0, '0, '0, 0, 1);

        applyStimulus("fl_fill1", 1, I_ADDI, 64'h200, 0, 0);
        applyStimulus("fl_fill2", 1, I_SW, 64'h204, 0, 0);
        applyStimulus("fl_full", 1, I_LUI, 64'h208, 1, 0);
        checkOutput("flush_full.o_valid", 64'(a_valid), 64'd0);
        checkOutput("flush_full.o_ready", 64'(a_ready), 64'd1);
        applyStimulus("fl_one", 1, I_BEQ, 64'h20C, 0, 0);
        applyStimulus("fl_push", 1, I_LUI, 64'h210, 1, 0);
        applyStimulus("fl_after", 0, '0, '0, 0, 1);
        checkOutput("flush_push.o_valid", 64'(b_valid), 64'd0);

        applyStimulus("ill_zero", 1, 32'h0000_0000, 64'h300, 0, 1);
        checkOutput("ill_zero.illegal", 64'(a_dec.illegal), 64'd1);
        applyStimulus("ill_707b", 1, 32'h0000_707B, 64'h304, 0, 1);
        checkOutput("ill_707b.illegal", 64'(b_dec.illegal), 64'd1);
        checkOutput("ill_707b.ctrl_flags", 64'(b_dec.ctrl[27:18]), 64'd0);
        applyStimulus("slli25", 1, I_SLLI, 64'h308, 0, 1);
        checkOutput("slli25.illegal32", 64'(a_dec.illegal), 64'd1);
        checkOutput("slli25.legal64", 64'(c_dec.illegal), 64'd0);
        applyStimulus("addiw", 1, I_ADDIW, 64'h30C, 0, 1);
        checkOutput("addiw.word_op", 64'(c_dec.word_op), 64'd1);
        applyStimulus("mul", 1, I_MUL, 64'h310, 0, 1);
        checkOutput("mul.illegal_nom", 64'(c_dec.illegal), 64'd1);
        checkOutput("mul.muldiv", 64'(b_dec.muldiv), 64'd1);
        checkOutput("mul.alu_reg", 64'(b_dec.ctrl.alu_reg), 64'd1);
        checkOutput("mul.iop", 64'(b_dec.ctrl.iop), 64'd0);
        applyStimulus("drain2", 0, '0, '0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", $urandom_range(0, 3) != 0, randInstr(), {$urandom, $urandom},
                          $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
